instr_mem_arbiter: RTL and testbench

- Shares the single combinational read port of the instruction memory between two requesters: CPU fetch (port F) and debug/loader read (port D).
- Grants at most one request per cycle, registers the read data and returns it one cycle later.
- Prevents debug starvation with a wait counter and supports a debug lock mode for burst reads.
- Sits between the PC/fetch logic, the debug interface and the instruction memory.

---
 rtl/imem_arb_pkg.sv | 18 +
 rtl/imem_resp_reg.sv | 36 +++
 rtl/instr_mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_instr_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
// Shared definitions for the instruction-memory arbiter: FSM state type,
// requester port indices and default widths.
package imem_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int PORT_F = 0;
    localparam int PORT_D = 1;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MEM_WORDS  = 32;
    localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/imem_resp_reg.sv
// Per-port response register: captures memory read data on the edge that
// ends a grant cycle and raises a one-cycle valid pulse. Data holds between
// grants so the idle port's output stays unchanged.
module imem_resp_reg
    import imem_arb_pkg::*;
#(
    parameter int W = DEF_DATA_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_gnt,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Valid follows the grant by one cycle; data is loaded only on a grant
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= i_gnt;
            if (i_gnt) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/instr_mem_arbiter.sv
// Two-port arbiter (fetch F, debug D) for the single combinational read
// port of the instruction memory. F has priority except when D has waited
// STARVE_MAX cycles; D can take exclusive ownership with d_lock_i.
// Optional build macro IMEM_ALIGN_CHECK_EN adds err_o and returns zero data
// for misaligned or out-of-range granted addresses.
module instr_mem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_WORDS  = DEF_MEM_WORDS,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              f_req_i,
    input  logic [ADDR_W-1:0] f_addr_i,
    output logic              f_gnt_o,
    output logic              f_valid_o,
    output logic [DATA_W-1:0] f_instr_o,
    input  logic              d_req_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic              d_lock_i,
    output logic              d_gnt_o,
    output logic              d_valid_o,
    output logic [DATA_W-1:0] d_instr_o,
`ifdef IMEM_ALIGN_CHECK_EN
    output logic              err_o,
`endif
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_instr_i,
    output logic              locked_o
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
`ifdef IMEM_ALIGN_CHECK_EN
    localparam int RESP_W = DATA_W + 1;
`else
    localparam int RESP_W = DATA_W;
`endif

    arb_state_t        r_state;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic [ADDR_W-1:0] r_last_addr;

    logic [1:0]        w_gnt;
    logic              w_lock_hold;
    logic              w_d_starved;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [RESP_W-1:0] w_resp_data;
    logic [RESP_W-1:0] w_f_resp;
    logic [RESP_W-1:0] w_d_resp;

`ifdef IMEM_ALIGN_CHECK_EN
    logic              w_addr_bad;

    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= ADDR_W'(MEM_WORDS));
    endfunction
`endif

    // LOCK persists only while d_lock_i stays high; the release cycle is
    // arbitrated with the normal ARB rules.
    assign w_lock_hold = (r_state == LOCK) && d_lock_i;
    assign w_d_starved = (r_starve_cnt == CNT_W'(STARVE_MAX));

    // Same-cycle grant decision
    always_comb begin
        w_gnt = 2'b00;
        if (w_lock_hold) begin
            w_gnt[PORT_D] = d_req_i;
        end else if (f_req_i && d_req_i) begin
            if (w_d_starved) begin
                w_gnt[PORT_D] = 1'b1;
            end else begin
                w_gnt[PORT_F] = 1'b1;
            end
        end else begin
            w_gnt[PORT_F] = f_req_i;
            w_gnt[PORT_D] = d_req_i;
        end
    end

    // Memory address follows the winner; with no grant it holds the last one
    always_comb begin
        w_mem_addr = r_last_addr;
        if (w_gnt[PORT_F]) begin
            w_mem_addr = f_addr_i;
        end else if (w_gnt[PORT_D]) begin
            w_mem_addr = d_addr_i;
        end
    end

    // Remember the last granted address for idle cycles
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last_addr <= '0;
        end else if (w_gnt != 2'b00) begin
            r_last_addr <= w_mem_addr;
        end
    end

    // Starvation counter: counts cycles D waits, saturates, forced to 0 in LOCK
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_starve_cnt <= '0;
        end else if (w_lock_hold || !d_req_i || w_gnt[PORT_D]) begin
            r_starve_cnt <= '0;
        end else if (!w_d_starved) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end

    // FSM: enter LOCK only on an actual D grant with lock requested
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ARB;
        end else begin
            case (r_state)
                ARB:     r_state <= (w_gnt[PORT_D] && d_lock_i) ? LOCK : ARB;
                LOCK:    r_state <= (w_lock_hold || (w_gnt[PORT_D] && d_lock_i)) ? LOCK : ARB;
                default: r_state <= ARB;
            endcase
        end
    end

`ifdef IMEM_ALIGN_CHECK_EN
    assign w_addr_bad  = addr_bad(w_mem_addr);
    assign w_resp_data = {w_addr_bad, (w_addr_bad ? {DATA_W{1'b0}} : mem_instr_i)};
`else
    assign w_resp_data = mem_instr_i;
`endif

    imem_resp_reg #(.W(RESP_W)) u_resp_f (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_gnt   (w_gnt[PORT_F]),
        .i_data  (w_resp_data),
        .o_valid (f_valid_o),
        .o_data  (w_f_resp)
    );

    imem_resp_reg #(.W(RESP_W)) u_resp_d (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_gnt   (w_gnt[PORT_D]),
        .i_data  (w_resp_data),
        .o_valid (d_valid_o),
        .o_data  (w_d_resp)
    );

    assign f_instr_o  = w_f_resp[DATA_W-1:0];
    assign d_instr_o  = w_d_resp[DATA_W-1:0];
`ifdef IMEM_ALIGN_CHECK_EN
    assign err_o      = (f_valid_o && w_f_resp[DATA_W]) || (d_valid_o && w_d_resp[DATA_W]);
`endif
    assign f_gnt_o    = w_gnt[PORT_F];
    assign d_gnt_o    = w_gnt[PORT_D];
    assign mem_addr_o = w_mem_addr;
    assign locked_o   = (r_state == LOCK);

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Bench for instr_mem_arbiter: table of per-cycle requests with expected
// grants, a scoreboard queue per port for response data, plus hand-written
// reset sequences.
module tb_instr_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_gnt;
    logic        f_valid;
    logic [31:0] f_instr;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_lock;
    logic        d_gnt;
    logic        d_valid;
    logic [31:0] d_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_instr;
    logic        locked;
`ifdef IMEM_ALIGN_CHECK_EN
    logic        err;
`endif

    logic [31:0] mem [32];

    typedef struct {
        logic        f_req;
        logic [31:0] f_addr;
        logic        d_req;
        logic [31:0] d_addr;
        logic        d_lock;
        logic        e_fg;
        logic        e_dg;
        logic        e_lk;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    vec_t        tbl[$];
    rsp_t        q_f[$];
    rsp_t        q_d[$];
    logic [31:0] last_f;
    logic [31:0] last_d;
    logic [31:0] last_addr;
    int          n_vec;
    int          n_bad;

    instr_mem_arbiter dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .f_req_i     (f_req),
        .f_addr_i    (f_addr),
        .f_gnt_o     (f_gnt),
        .f_valid_o   (f_valid),
        .f_instr_o   (f_instr),
        .d_req_i     (d_req),
        .d_addr_i    (d_addr),
        .d_lock_i    (d_lock),
        .d_gnt_o     (d_gnt),
        .d_valid_o   (d_valid),
        .d_instr_o   (d_instr),
`ifdef IMEM_ALIGN_CHECK_EN
        .err_o       (err),
`endif
        .mem_addr_o  (mem_addr),
        .mem_instr_i (mem_instr),
        .locked_o    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational memory model
    always_comb mem_instr = mem[mem_addr[6:2]];

    function automatic rsp_t exp_rsp(input logic [31:0] a);
        rsp_t r;
        r.data = mem[a[6:2]];
        r.err  = 1'b0;
`ifdef IMEM_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00 || a[31:2] >= 30'd32) begin
            r.data = 32'h0;
            r.err  = 1'b1;
        end
`endif
        return r;
    endfunction

    function automatic vec_t mk(input logic fr, input logic [31:0] fa, input logic dr,
                                input logic [31:0] da, input logic lk,
                                input logic efg, input logic edg, input logic elk);
        vec_t v;
        v.f_req = fr; v.f_addr = fa; v.d_req = dr; v.d_addr = da; v.d_lock = lk;
        v.e_fg = efg; v.e_dg = edg; v.e_lk = elk;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare response outputs against the scoreboard (called at negedge)
    task automatic check_resp();
        rsp_t e;
        logic e_err;
        e_err = 1'b0;
        chk("f_valid", {31'b0, f_valid}, {31'b0, (q_f.size() != 0)});
        if (q_f.size() != 0) begin
            e = q_f.pop_front();
            last_f = e.data;
            e_err = e_err | e.err;
        end
        chk("f_instr", f_instr, last_f);
        chk("d_valid", {31'b0, d_valid}, {31'b0, (q_d.size() != 0)});
        if (q_d.size() != 0) begin
            e = q_d.pop_front();
            last_d = e.data;
            e_err = e_err | e.err;
        end
        chk("d_instr", d_instr, last_d);
`ifdef IMEM_ALIGN_CHECK_EN
        chk("err", {31'b0, err}, {31'b0, e_err});
`endif
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        check_resp();
        f_req  = v.f_req;
        f_addr = v.f_addr;
        d_req  = v.d_req;
        d_addr = v.d_addr;
        d_lock = v.d_lock;
        #1;
        chk("f_gnt", {31'b0, f_gnt}, {31'b0, v.e_fg});
        chk("d_gnt", {31'b0, d_gnt}, {31'b0, v.e_dg});
        chk("locked", {31'b0, locked}, {31'b0, v.e_lk});
        if (v.e_fg) begin
            last_addr = v.f_addr;
            q_f.push_back(exp_rsp(v.f_addr));
        end else if (v.e_dg) begin
            last_addr = v.d_addr;
            q_d.push_back(exp_rsp(v.d_addr));
        end
        chk("mem_addr", mem_addr, last_addr);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_f_valid"}, {31'b0, f_valid}, 32'h0);
        chk({tag, "_d_valid"}, {31'b0, d_valid}, 32'h0);
        chk({tag, "_f_instr"}, f_instr, 32'h0);
        chk({tag, "_d_instr"}, d_instr, 32'h0);
        chk({tag, "_locked"}, {31'b0, locked}, 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_f_gnt"}, {31'b0, f_gnt}, 32'h0);
        chk({tag, "_d_gnt"}, {31'b0, d_gnt}, 32'h0);
    endtask

    initial begin
        rsp_t e;
        vec_t idle;
        n_vec = 0;
        n_bad = 0;
        last_f = 0;
        last_d = 0;
        last_addr = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE_0000 + (i * 32'h0001_0103);
        mem[2] = 32'h2008_0005;

        rst = 1'b1;
        f_req = 0; f_addr = 0; d_req = 0; d_addr = 0; d_lock = 0;
        #3;
        check_reset_state("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        idle = mk(0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
        // F only
        tbl.push_back(mk(1, 32'h8, 0, 32'h0, 0, 1, 0, 0));
        tbl.push_back(idle);
        // Contention: F x4, then starved D, then F again
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 32'h10, 1, 32'h14, 0, 1, 0, 0));
        tbl.push_back(mk(1, 32'h10, 1, 32'h14, 0, 0, 1, 0));
        tbl.push_back(mk(1, 32'h10, 1, 32'h14, 0, 1, 0, 0));
        tbl.push_back(idle);
        // D withdraws after losing once; counter must restart from 0
        tbl.push_back(mk(1, 32'h18, 1, 32'h1C, 0, 1, 0, 0));
        tbl.push_back(mk(1, 32'h18, 0, 32'h1C, 0, 1, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 32'h20, 1, 32'h24, 0, 1, 0, 0));
        tbl.push_back(mk(1, 32'h20, 1, 32'h24, 0, 0, 1, 0));
        tbl.push_back(idle);
        // Lock requested but F wins: lock must not be taken
        tbl.push_back(mk(1, 32'h28, 1, 32'h2C, 1, 1, 0, 0));
        tbl.push_back(idle);
        // Lock burst with F waiting, then release grants F the same cycle
        tbl.push_back(mk(0, 32'h0,  1, 32'h0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 32'h30, 1, 32'h4, 1, 0, 1, 1));
        tbl.push_back(mk(1, 32'h30, 1, 32'h8, 1, 0, 1, 1));
        tbl.push_back(mk(1, 32'h30, 0, 32'h8, 1, 0, 0, 1));
        tbl.push_back(mk(1, 32'h30, 0, 32'h8, 0, 1, 0, 1));
        tbl.push_back(idle);
        tbl.push_back(idle);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Async reset right after an F grant
        @(negedge clk);
        check_resp();
        f_req = 1; f_addr = 32'hC; d_req = 0; d_lock = 0;
        #1;
        chk("rst_seq_f_gnt", {31'b0, f_gnt}, 32'h1);
        @(posedge clk);
        #2;
        e = exp_rsp(32'hC);
        chk("rst_seq_f_valid_pre", {31'b0, f_valid}, 32'h1);
        chk("rst_seq_f_instr_pre", f_instr, e.data);
        rst = 1'b1;
        f_req = 0;
        #1;
        check_reset_state("midrst");
        q_f.delete();
        q_d.delete();
        last_f = 0;
        last_d = 0;
        last_addr = 0;
        @(negedge clk);
        rst = 1'b0;
        apply(idle);
        apply(idle);

        // Alignment/range corner addresses, then an aligned read
        apply(mk(1, 32'h6,  0, 32'h0, 0, 1, 0, 0));
        apply(mk(1, 32'h80, 0, 32'h0, 0, 1, 0, 0));
        apply(mk(1, 32'h4,  0, 32'h0, 0, 1, 0, 0));
        apply(idle);
        apply(idle);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
